// File: rtl/adc_spi_reader_if.sv
`default_nettype none
// ============================================================================
//  Module      : adc_spi_reader_if
//  Description : Sample stream (valid/ready) carrying 32-bit ADC results
//                from the SPI reader to the downstream FIFO/DMA.
//  Revision    : 1.0  initial release
// ============================================================================
interface adc_spi_reader_if;
  logic [31:0] m_data;
  logic        m_valid;
  logic        m_ready;

  modport master (
    output m_data,
    output m_valid,
    input  m_ready
  );

  modport slave (
    input  m_data,
    input  m_valid,
    output m_ready
  );
endinterface
`default_nettype wire

// File: rtl/adc_spi_reader.sv
`default_nettype none
// ============================================================================
//  Module      : adc_spi_reader
//  Description : Multi-lane SAR ADC controller. Issues cnv, waits for busy,
//                clocks out 1/2/4-lane results into 32-bit stream words and
//                runs the three-transaction lane-mode register sequence.
//  Revision    : 1.0  initial release
// ============================================================================
module adc_spi_reader #(
  parameter int SCK_HALF     = 2,
  parameter int CNV_HIGH     = 4,
  parameter int BUSY_TIMEOUT = 1023
) (
  input  wire logic        clk,
  input  wire logic        resetn,
  input  wire logic        trigger,
  input  wire logic        cfg_start,
  input  wire logic [1:0]  cfg_lane_md,
  output      logic        cfg_done,
  output      logic [1:0]  lane_md,
  output      logic        cnv,
  input  wire logic        busy,
  output      logic        sck,
  output      logic        csn,
  output      logic        sdi,
  input  wire logic [3:0]  sdo,
  adc_spi_reader_if.master stream,
  output      logic        overrun,
  output      logic        timeout
);

  // Counter must hold the longest interval it times.
  localparam int CNT_MAX_A = (CNV_HIGH > 2 * SCK_HALF) ? CNV_HIGH : 2 * SCK_HALF;
  localparam int CNT_MAX   = (BUSY_TIMEOUT > CNT_MAX_A) ? BUSY_TIMEOUT : CNT_MAX_A;
  localparam int CNT_W     = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] HALF_LAST   = CNT_W'(SCK_HALF - 1);
  localparam logic [CNT_W-1:0] GAP_LAST    = CNT_W'(2 * SCK_HALF - 1);
  localparam logic [CNT_W-1:0] CNV_LAST    = CNT_W'(CNV_HIGH - 1);
  localparam logic [CNT_W-1:0] TO_LAST     = CNT_W'(BUSY_TIMEOUT - 1);
  // busy is only trusted from the third cycle after cnv falls
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(2);

  localparam logic [23:0] TXN0_WORD = 24'hA0_0000;
  localparam logic [23:0] TXN2_WORD = {1'b0, 15'h0014, 8'h01};

  localparam logic [5:0] CFG_BITS_LAST = 6'd23;
  localparam logic [5:0] CFG_BITS_DONE = 6'd24;

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_CNV_HI    = 3'd1;
  localparam logic [2:0] S_CONV_WAIT = 3'd2;
  localparam logic [2:0] S_CS_SETUP  = 3'd3;
  localparam logic [2:0] S_SHIFT     = 3'd4;
  localparam logic [2:0] S_CS_HOLD   = 3'd5;
  localparam logic [2:0] S_CFG_SHIFT = 3'd6;
  localparam logic [2:0] S_CFG_GAP   = 3'd7;

  logic [2:0]       state_q,    state_d;
  logic [CNT_W-1:0] cnt_q,      cnt_d;
  logic [5:0]       bit_cnt_q,  bit_cnt_d;
  logic [1:0]       txn_q,      txn_d;
  logic [1:0]       cfg_md_q,   cfg_md_d;
  logic [1:0]       lane_md_q,  lane_md_d;
  logic [23:0]      cfg_sr_q,   cfg_sr_d;
  logic [31:0]      data_q,     data_d;
  logic [31:0]      m_data_q,   m_data_d;
  logic             m_valid_q,  m_valid_d;
  logic             cnv_q,      cnv_d;
  logic             sck_q,      sck_d;
  logic             csn_q,      csn_d;
  logic             overrun_q,  overrun_d;
  logic             timeout_q,  timeout_d;
  logic             cfg_done_q, cfg_done_d;
  logic             busy_s1_q,  busy_s2_q;

  logic        half_done;
  logic        busy_settled;
  logic        shift_last;
  logic [5:0]  shift_last_idx;
  logic [31:0] data_shifted;
  logic [23:0] txn1_word;

  assign half_done    = (cnt_q == HALF_LAST);
  assign busy_settled = (cnt_q >= SETTLE_LAST) && !busy_s2_q;
  assign shift_last   = (bit_cnt_q == shift_last_idx);
  assign txn1_word    = {1'b0, 15'h0020, cfg_md_q, 6'b0};

  // Lane-mode dependent period count and deserialiser; the ADC emits lanes
  // bit-reversed, so the lowest lane carries the most significant bit.
  always_comb begin
    case (lane_md_q)
      2'b01: begin
        shift_last_idx = 6'd15;
        data_shifted   = {data_q[29:0], sdo[0], sdo[1]};
      end
      2'b10: begin
        shift_last_idx = 6'd7;
        data_shifted   = {data_q[27:0], sdo[0], sdo[1], sdo[2], sdo[3]};
      end
      default: begin
        shift_last_idx = 6'd31;
        data_shifted   = {data_q[30:0], sdo[0]};
      end
    endcase
  end

  // Two-flop synchroniser for the asynchronous busy input.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      busy_s1_q <= 1'b0;
      busy_s2_q <= 1'b0;
    end else begin
      busy_s1_q <= busy;
      busy_s2_q <= busy_s1_q;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (cfg_start)    state_d = S_CFG_SHIFT;
        else if (trigger) state_d = S_CNV_HI;
      end
      S_CNV_HI: begin
        if (cnt_q == CNV_LAST) state_d = S_CONV_WAIT;
      end
      S_CONV_WAIT: begin
        if (busy_settled)          state_d = S_CS_SETUP;
        else if (cnt_q == TO_LAST) state_d = S_IDLE;
      end
      S_CS_SETUP: begin
        if (half_done) state_d = S_SHIFT;
      end
      S_SHIFT: begin
        if (half_done && sck_q && shift_last) state_d = S_CS_HOLD;
      end
      S_CS_HOLD: begin
        if (half_done) state_d = S_IDLE;
      end
      S_CFG_SHIFT: begin
        if (half_done && !sck_q && (bit_cnt_q == CFG_BITS_DONE))
          state_d = (txn_q == 2'd2) ? S_IDLE : S_CFG_GAP;
      end
      S_CFG_GAP: begin
        if (cnt_q == GAP_LAST) state_d = S_CFG_SHIFT;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output and datapath logic: pin timing, capture, stream and pulses.
  always_comb begin
    cnt_d      = cnt_q + CNT_W'(1);
    bit_cnt_d  = bit_cnt_q;
    txn_d      = txn_q;
    cfg_md_d   = cfg_md_q;
    lane_md_d  = lane_md_q;
    cfg_sr_d   = cfg_sr_q;
    data_d     = data_q;
    m_data_d   = m_data_q;
    m_valid_d  = m_valid_q && !stream.m_ready;
    cnv_d      = cnv_q;
    sck_d      = sck_q;
    csn_d      = csn_q;
    timeout_d  = 1'b0;
    cfg_done_d = 1'b0;
    // a trigger is only honoured in IDLE and loses to a same-cycle cfg_start
    overrun_d  = trigger && ((state_q != S_IDLE) || cfg_start);

    case (state_q)
      S_IDLE: begin
        cnt_d     = '0;
        bit_cnt_d = '0;
        if (cfg_start) begin
          csn_d    = 1'b0;
          txn_d    = 2'd0;
          cfg_md_d = (cfg_lane_md == 2'b11) ? 2'b00 : cfg_lane_md;
          cfg_sr_d = TXN0_WORD;
        end else if (trigger) begin
          cnv_d = 1'b1;
        end
      end
      S_CNV_HI: begin
        if (cnt_q == CNV_LAST) begin
          cnv_d = 1'b0;
          cnt_d = '0;
        end
      end
      S_CONV_WAIT: begin
        if (busy_settled) begin
          csn_d  = 1'b0;
          cnt_d  = '0;
          data_d = '0;
        end else if (cnt_q == TO_LAST) begin
          timeout_d = 1'b1;
        end
      end
      S_CS_SETUP: begin
        if (half_done) begin
          sck_d     = 1'b1;
          cnt_d     = '0;
          bit_cnt_d = '0;
          data_d    = data_shifted;
        end
      end
      S_SHIFT: begin
        if (half_done) begin
          cnt_d = '0;
          if (sck_q) begin
            sck_d     = 1'b0;
            bit_cnt_d = bit_cnt_q + 6'd1;
          end else begin
            sck_d  = 1'b1;
            data_d = data_shifted;
          end
        end
      end
      S_CS_HOLD: begin
        if (half_done) begin
          csn_d = 1'b1;
          if (!m_valid_q || stream.m_ready) begin
            m_data_d  = data_q;
            m_valid_d = 1'b1;
          end else begin
            overrun_d = 1'b1;
          end
        end
      end
      S_CFG_SHIFT: begin
        if (half_done) begin
          cnt_d = '0;
          if (sck_q) begin
            // the 24th shift leaves the register, and so sdi, at zero
            sck_d     = 1'b0;
            cfg_sr_d  = {cfg_sr_q[22:0], 1'b0};
            bit_cnt_d = (bit_cnt_q == CFG_BITS_LAST) ? CFG_BITS_DONE : bit_cnt_q + 6'd1;
          end else if (bit_cnt_q == CFG_BITS_DONE) begin
            csn_d = 1'b1;
            if (txn_q == 2'd2) begin
              lane_md_d  = cfg_md_q;
              cfg_done_d = 1'b1;
            end else begin
              txn_d = txn_q + 2'd1;
            end
          end else begin
            sck_d = 1'b1;
          end
        end
      end
      S_CFG_GAP: begin
        if (cnt_q == GAP_LAST) begin
          csn_d     = 1'b0;
          cnt_d     = '0;
          bit_cnt_d = '0;
          cfg_sr_d  = (txn_q == 2'd1) ? txn1_word : TXN2_WORD;
        end
      end
      default: begin
        cnt_d = '0;
      end
    endcase
  end

  // Datapath and pin registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt_q      <= '0;
      bit_cnt_q  <= '0;
      txn_q      <= '0;
      cfg_md_q   <= '0;
      lane_md_q  <= '0;
      cfg_sr_q   <= '0;
      data_q     <= '0;
      m_data_q   <= '0;
      m_valid_q  <= 1'b0;
      cnv_q      <= 1'b0;
      sck_q      <= 1'b0;
      csn_q      <= 1'b1;
      overrun_q  <= 1'b0;
      timeout_q  <= 1'b0;
      cfg_done_q <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      txn_q      <= txn_d;
      cfg_md_q   <= cfg_md_d;
      lane_md_q  <= lane_md_d;
      cfg_sr_q   <= cfg_sr_d;
      data_q     <= data_d;
      m_data_q   <= m_data_d;
      m_valid_q  <= m_valid_d;
      cnv_q      <= cnv_d;
      sck_q      <= sck_d;
      csn_q      <= csn_d;
      overrun_q  <= overrun_d;
      timeout_q  <= timeout_d;
      cfg_done_q <= cfg_done_d;
    end
  end

  assign cnv            = cnv_q;
  assign sck            = sck_q;
  assign csn            = csn_q;
  assign sdi            = cfg_sr_q[23];
  assign lane_md        = lane_md_q;
  assign cfg_done       = cfg_done_q;
  assign overrun        = overrun_q;
  assign timeout        = timeout_q;
  assign stream.m_data  = m_data_q;
  assign stream.m_valid = m_valid_q;

endmodule
`default_nettype wire

// File: doc/adc_spi_reader.md
Name: adc_spi_reader

Overview:
- FPGA-side controller for the multi-lane SAR ADC. Drives cnv, sck, csn and sdi, and captures the ADC's 1/2/4-lane sdo.
- Assembles each conversion result into a 32-bit word on a valid/ready stream.
- Also runs the 3-transaction register sequence that sets the ADC lane mode. The captured lane mode is held locally so deserialisation matches the ADC.
- Sits between the ADC pins and the downstream sample FIFO/DMA.

Parameters:
- SCK_HALF, 2, clk cycles per sck half-period (>=1).
- CNV_HIGH, 4, clk cycles cnv is held high.
- BUSY_TIMEOUT, 1023, clk cycles to wait for busy low after cnv before aborting.

Ports:
- clk  in  1  system clock.
- resetn  in  1  reset, asynchronous, active-low.
- trigger  in  1  single-cycle conversion request.
- cfg_start  in  1  single-cycle request to program lane mode.
- cfg_lane_md  in  2  requested mode: 00=1 lane, 01=2 lanes, 10=4 lanes.
- cfg_done  out  1  one-cycle pulse when the config sequence completes.
- lane_md  out  2  currently active lane mode.
- cnv  out  1  ADC convert start.
- busy  in  1  ADC busy, asynchronous; 2-flop synchronised internally.
- sck  out  1  SPI clock, idle low.
- csn  out  1  SPI chip select, idle high.
- sdi  out  1  SPI data to ADC, MSB first.
- sdo  in  4  ADC data lanes.
- m_data  out  32  sample.
- m_valid  out  1  sample valid.
- m_ready  in  1  downstream accept.
- overrun  out  1  one-cycle pulse: trigger ignored or sample dropped.
- timeout  out  1  one-cycle pulse: busy did not fall within BUSY_TIMEOUT.

Behaviour:
- Reset values: cnv=0, sck=0, csn=1, sdi=0, m_data=0, m_valid=0, lane_md=00, all pulses 0. Reset mid-transfer returns to IDLE immediately with these values. Any partial sample is discarded.
- States: IDLE, CNV_HI, CONV_WAIT, CS_SETUP, SHIFT, CS_HOLD, CFG_SHIFT, CFG_GAP.
- IDLE:
  - cfg_start takes priority over a same-cycle trigger; that trigger raises overrun.
  - trigger -> CNV_HI.
  - cfg_start -> CFG_SHIFT with txn=0, cfg_lane_md latched.
- CNV_HI: cnv=1 for CNV_HIGH cycles -> CONV_WAIT.
- CONV_WAIT:
  - Wait for synchronised busy low, no earlier than 3 cycles after cnv falls.
  - Then csn=0 and go to CS_SETUP (SCK_HALF cycles).
  - If counter reaches BUSY_TIMEOUT: pulse timeout, return to IDLE.
- SHIFT:
  - Produce N=32/lanes sck periods (32, 16 or 8).
  - sdo is sampled on the clk edge that drives sck 0->1.
  - 1 lane: data <= {data[30:0], sdo[0]}.
  - 2 lanes: data <= {data[29:0], sdo[0], sdo[1]}.
  - 4 lanes: data <= {data[27:0], sdo[0], sdo[1], sdo[2], sdo[3]}. The ADC emits lanes bit-reversed, so sdo[0] carries the higher bit.
  - After the Nth high phase, sck returns low -> CS_HOLD.
- CS_HOLD: SCK_HALF cycles, then csn=1.
  - If m_valid=0 or m_ready=1 that cycle: m_data<=data, m_valid<=1.
  - Otherwise keep the old sample, drop the new one, pulse overrun.
  - -> IDLE.
- Stream: m_valid stays high until m_valid&&m_ready. m_data is stable while valid.
- trigger in any non-IDLE state is ignored and pulses overrun.
- CFG_SHIFT: three 24-bit transactions, MSB first. Each has csn low, 24 sck periods and csn high, with ≥2*SCK_HALF cycles of csn high between transactions (CFG_GAP).
  - txn0 = 0xA00000: enter register access.
  - txn1 = {1'b0, 15'h0020, cfg_lane_md, 6'b0}: mode register.
  - txn2 = {1'b0, 15'h0014, 8'h01}: exit register access.
  - sdi is updated at csn fall and on each sck 1->0. The ADC samples it on sck 0->1.
  - After txn2 csn rises: lane_md <= latched mode, pulse cfg_done, -> IDLE.
  - cfg_lane_md=11 is treated as 00.
- sdo is ignored outside SHIFT. sdi=0 outside CFG_SHIFT.

Test Plan:
- Reset, then trigger with ADC pattern 0xA5C30F96, 1 lane, SCK_HALF=2 -> cnv high 4 cycles, 32 sck pulses, m_data=0xA5C30F96, m_valid high until m_ready.
- cfg_start with cfg_lane_md=10 -> sdi streams 0xA00000, 0x002080, 0x001401 over three csn windows. cfg_done pulses once and lane_md=10. A following trigger gives 8 sck pulses and m_data=0xA5C30F96.
- cfg_lane_md=01, then trigger with pattern 0x12345678 -> 16 sck pulses, m_data=0x12345678.
- m_ready=0, two triggers -> first sample held (m_valid=1, m_data unchanged), overrun pulses once at the second CS_HOLD. A trigger during SHIFT also pulses overrun.
- busy held high, BUSY_TIMEOUT=20 -> timeout pulses, csn never falls, state returns to IDLE.
- resetn low during SHIFT at bit 10 -> csn=1, sck=0, m_valid=0, lane_md=00 immediately. The next trigger yields a correct full sample.
